// File: rtl/atm_pkg.sv
// Shared widths, status codes and FSM states for the ATM card/PIN blocks.
// The PIN-change and withdraw blocks import the same definitions.
package atm_pkg;

  localparam int CARD_W_DEF    = 10;
  localparam int PIN_W_DEF     = 11;
  localparam int USERS_N_DEF   = 4;
  localparam int MAX_TRIES_DEF = 3;
  localparam int CNT_W         = 2;

  typedef enum logic [1:0] {
    ST_OK      = 2'b00,
    ST_BAD_PIN = 2'b01,
    ST_NO_CARD = 2'b10,
    ST_LOCKED  = 2'b11
  } status_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RD   = 2'b01,
    CMP  = 2'b10,
    RESP = 2'b11
  } state_e;

endpackage

// File: rtl/atm_fail_counter_bank.sv
// Per-user saturating failed-attempt counters with an unlock port that
// overrides any same-cycle update, plus a combinational read mux.
module atm_fail_counter_bank
  import atm_pkg::*;
#(
  parameter int N         = USERS_N_DEF,
  parameter int IW        = (N < 1) ? 1 : $clog2(N + 1),
  parameter int MAX_TRIES = MAX_TRIES_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  input  logic [IW-1:0]    upd_idx,
  input  logic             unlock_valid,
  input  logic [IW-1:0]    unlock_idx,
  input  logic [IW-1:0]    rd_idx,
  output logic [CNT_W-1:0] rd_cnt
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_TRIES);

  logic [CNT_W-1:0] cnt [0:N];

  // Unlock beats clr/inc; an unlock index beyond N matches no counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i <= N; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i <= N; i++) begin
        if (unlock_valid && unlock_idx == IW'(i)) begin
          cnt[i] <= '0;
        end else if (clr && upd_idx == IW'(i)) begin
          cnt[i] <= '0;
        end else if (inc && upd_idx == IW'(i) && cnt[i] != MAX_CNT) begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    rd_cnt = '0;
    for (int i = 0; i <= N; i++) begin
      if (rd_idx == IW'(i)) rd_cnt = cnt[i];
    end
  end

endmodule

// File: rtl/atm_pin_verifier.sv
// Authenticates a card/PIN request by scanning the card store through a
// synchronous read port, tracking failed attempts and locking cards.
module atm_pin_verifier
  import atm_pkg::*;
#(
  parameter int N         = USERS_N_DEF,
  parameter int CARD_W    = CARD_W_DEF,
  parameter int PIN_W     = PIN_W_DEF,
  parameter int MAX_TRIES = MAX_TRIES_DEF,
  parameter int IW        = (N < 1) ? 1 : $clog2(N + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [CARD_W-1:0] req_card,
  input  logic [PIN_W-1:0]  req_pin,
  output logic              rd_en,
  output logic [IW-1:0]     rd_addr,
  input  logic [CARD_W-1:0] rd_card,
  input  logic [PIN_W-1:0]  rd_pin,
  output logic              resp_valid,
  output logic [1:0]        resp_status,
  output logic [IW-1:0]     resp_idx,
  output logic [1:0]        resp_tries,
  input  logic              unlock_valid,
  input  logic [IW-1:0]     unlock_idx
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_TRIES);

  state_e            state;
  logic [CARD_W-1:0] card;
  logic [PIN_W-1:0]  pin;
  logic [IW-1:0]     idx;
  logic [CNT_W-1:0]  cnt_cur;
  logic [CNT_W-1:0]  tries_new;
  logic              match;
  logic              locked;
  logic              pin_ok;
  logic              last;
  logic              cnt_inc;
  logic              cnt_clr;

  assign match   = (rd_card == card);
  assign locked  = (cnt_cur == MAX_CNT);
  assign pin_ok  = (rd_pin == pin);
  assign last    = (idx == IW'(N));
  assign cnt_inc = (state == CMP) && match && !locked && !pin_ok;
  assign cnt_clr = (state == CMP) && match && !locked && pin_ok;

  atm_fail_counter_bank #(
    .N         (N),
    .IW        (IW),
    .MAX_TRIES (MAX_TRIES)
  ) u_fail_cnt (
    .clk          (clk),
    .rst_n        (rst_n),
    .inc          (cnt_inc),
    .clr          (cnt_clr),
    .upd_idx      (idx),
    .unlock_valid (unlock_valid),
    .unlock_idx   (unlock_idx),
    .rd_idx       (idx),
    .rd_cnt       (cnt_cur)
  );

  // Counter value as it will stand after this CMP; a same-cycle unlock wins.
  always_comb begin
    tries_new = cnt_cur;
    if (unlock_valid && unlock_idx == idx) begin
      tries_new = '0;
    end else if (locked) begin
      tries_new = cnt_cur;
    end else if (pin_ok) begin
      tries_new = '0;
    end else begin
      tries_new = cnt_cur + CNT_W'(1);
    end
  end

  // Outputs are registered on entry to the state they belong to, so the
  // store sees rd_en during RD and its data is valid during CMP.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      req_ready   <= 1'b1;
      rd_en       <= 1'b0;
      rd_addr     <= '0;
      resp_valid  <= 1'b0;
      resp_status <= ST_OK;
      resp_idx    <= '0;
      resp_tries  <= '0;
      card        <= '0;
      pin         <= '0;
      idx         <= '0;
    end else begin
      rd_en      <= 1'b0;
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            card      <= req_card;
            pin       <= req_pin;
            idx       <= '0;
            rd_en     <= 1'b1;
            rd_addr   <= '0;
            req_ready <= 1'b0;
            state     <= RD;
          end
        end
        RD: begin
          state <= CMP;
        end
        CMP: begin
          if (match) begin
            resp_valid  <= 1'b1;
            resp_idx    <= idx;
            resp_tries  <= tries_new;
            resp_status <= locked ? ST_LOCKED : (pin_ok ? ST_OK : ST_BAD_PIN);
            state       <= RESP;
          end else if (last) begin
            resp_valid  <= 1'b1;
            resp_idx    <= '0;
            resp_tries  <= '0;
            resp_status <= ST_NO_CARD;
            state       <= RESP;
          end else begin
            idx     <= idx + IW'(1);
            rd_en   <= 1'b1;
            rd_addr <= idx + IW'(1);
            state   <= RD;
          end
        end
        RESP: begin
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          req_ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_atm_pin_verifier.sv
// Directed bench for atm_pin_verifier: a behavioural card store and a
// search-based reference model, checked every cycle by one compare process.
module tb_atm_pin_verifier;

  localparam int N      = 4;
  localparam int IW     = 3;
  localparam int MAXT   = 3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic [9:0]      req_card = '0;
  logic [10:0]     req_pin = '0;
  logic            rd_en;
  logic [IW-1:0]   rd_addr;
  logic [9:0]      rd_card = '0;
  logic [10:0]     rd_pin = '0;
  logic            resp_valid;
  logic [1:0]      resp_status;
  logic [IW-1:0]   resp_idx;
  logic [1:0]      resp_tries;
  logic            unlock_valid = 1'b0;
  logic [IW-1:0]   unlock_idx = '0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [9:0]  store_card [0:N];
  logic [10:0] store_pin  [0:N];
  int          addr_log [$];

  int model_fail [0:N];
  int exp_status, exp_idx, exp_tries, exp_lat;
  int exp_addrs [$];

  bit chk_en = 1'b0;
  bit txn_active = 1'b0;
  int acc_cycle = 0;
  int resp_cycle = 0;
  bit resp_seen = 1'b0;
  int obs_lat, obs_status, obs_idx, obs_tries;

  atm_pin_verifier #(
    .N (N), .CARD_W (10), .PIN_W (11), .MAX_TRIES (MAXT), .IW (IW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_card     (req_card),
    .req_pin      (req_pin),
    .rd_en        (rd_en),
    .rd_addr      (rd_addr),
    .rd_card      (rd_card),
    .rd_pin       (rd_pin),
    .resp_valid   (resp_valid),
    .resp_status  (resp_status),
    .resp_idx     (resp_idx),
    .resp_tries   (resp_tries),
    .unlock_valid (unlock_valid),
    .unlock_idx   (unlock_idx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read card store; also logs every address it is asked for.
  always @(posedge clk) begin
    if (rd_en) begin
      rd_card <= store_card[rd_addr];
      rd_pin  <= store_pin[rd_addr];
      addr_log.push_back(int'(rd_addr));
    end
  end

  function automatic void check_output(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference model: first matching store entry decides the outcome.
  task automatic model_req(input int card, input int pin, input bit uh, input int uidx);
    int k;
    k = -1;
    exp_addrs.delete();
    for (int i = 0; i <= N; i++) begin
      exp_addrs.push_back(i);
      if (int'(store_card[i]) == card) begin
        k = i;
        break;
      end
    end
    if (uh && uidx <= N) model_fail[uidx] = 0;
    if (k < 0) begin
      exp_status = 2;
      exp_idx    = 0;
      exp_tries  = 0;
      exp_lat    = 3 + 2 * N;
    end else begin
      exp_idx = k;
      exp_lat = 3 + 2 * k;
      if (model_fail[k] == MAXT) begin
        exp_status = 3;
      end else if (int'(store_pin[k]) == pin) begin
        exp_status = 0;
        model_fail[k] = 0;
      end else begin
        exp_status = 1;
        model_fail[k] = (model_fail[k] + 1 > MAXT) ? MAXT : model_fail[k] + 1;
      end
      if (uh && uidx == k) model_fail[k] = 0;
      exp_tries = model_fail[k];
    end
  endtask

  // Single compare process; cycle numbering makes the request cycle T0.
  always @(negedge clk) begin
    int cur;
    bit exp_rv, exp_rdy;
    if (chk_en) begin
      cur     = cyc + 1;
      exp_rv  = txn_active && (cur == resp_cycle);
      exp_rdy = !(txn_active && cur > acc_cycle && cur <= resp_cycle);
      check_output("resp_valid", int'(resp_valid), int'(exp_rv));
      check_output("req_ready", int'(req_ready), int'(exp_rdy));
      if (resp_valid && txn_active && !resp_seen) begin
        resp_seen  = 1'b1;
        obs_lat    = cur - acc_cycle;
        obs_status = int'(resp_status);
        obs_idx    = int'(resp_idx);
        obs_tries  = int'(resp_tries);
        if (exp_rv) begin
          check_output("resp_status", obs_status, exp_status);
          check_output("resp_idx", obs_idx, exp_idx);
          if (exp_status != 2) check_output("resp_tries", obs_tries, exp_tries);
        end
      end
    end
  end

  task automatic apply_stimulus(input int card, input int pin, input bit uh,
                                input int uidx, input bit wait_resp);
    @(negedge clk);
    req_valid = 1'b1;
    req_card  = 10'(card);
    req_pin   = 11'(pin);
    if (uh) begin
      unlock_valid = 1'b1;
      unlock_idx   = IW'(uidx);
    end
    model_req(card, pin, uh, uidx);
    addr_log.delete();
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    resp_seen  = 1'b0;
    acc_cycle  = cyc;
    resp_cycle = cyc + exp_lat;
    txn_active = 1'b1;
    if (wait_resp) begin
      for (int c = 0; c < 40 && !resp_seen; c++) @(negedge clk);
      if (!resp_seen) check_output("resp_timeout", 0, 1);
      check_output("latency", obs_lat, exp_lat);
      check_output("addr_count", addr_log.size(), exp_addrs.size());
      for (int i = 0; i < exp_addrs.size() && i < addr_log.size(); i++)
        check_output("rd_addr_seq", addr_log[i], exp_addrs[i]);
      unlock_valid = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic pulse_unlock(input int uidx);
    @(negedge clk);
    unlock_valid = 1'b1;
    unlock_idx   = IW'(uidx);
    if (uidx <= N) model_fail[uidx] = 0;
    @(negedge clk);
    unlock_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i <= N; i++) begin
      store_card[i] = 10'(100 * (i + 1));
      store_pin[i]  = 11'(1111 + 111 * i);
      model_fail[i] = 0;
    end
    store_pin[1] = 11'd1222;
    store_pin[2] = 11'd1333;
    store_pin[3] = 11'd1444;
    store_pin[4] = 11'd1555;

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_output("rst_req_ready", int'(req_ready), 1);
    check_output("rst_rd_en", int'(rd_en), 0);
    check_output("rst_rd_addr", int'(rd_addr), 0);
    check_output("rst_resp_valid", int'(resp_valid), 0);
    check_output("rst_resp_status", int'(resp_status), 0);
    check_output("rst_resp_idx", int'(resp_idx), 0);
    check_output("rst_resp_tries", int'(resp_tries), 0);
    chk_en = 1'b1;

    // Card 300 / correct PIN: OK at index 2, seven cycles after T0.
    apply_stimulus(300, 1333, 0, 0, 1);
    check_output("ok300_lat", obs_lat, 7);
    check_output("ok300_status", obs_status, 0);
    check_output("ok300_idx", obs_idx, 2);
    check_output("ok300_tries", obs_tries, 0);
    check_output("ok300_last_addr", addr_log[addr_log.size()-1], 2);

    // Unknown card scans every entry.
    apply_stimulus(999, 42, 0, 0, 1);
    check_output("nocard_lat", obs_lat, 11);
    check_output("nocard_status", obs_status, 2);
    check_output("nocard_idx", obs_idx, 0);
    check_output("nocard_addrs", addr_log.size(), 5);

    // Three bad PINs then a correct one on a locked card.
    for (int t = 1; t <= 3; t++) begin
      apply_stimulus(100, 5, 0, 0, 1);
      check_output("bad_status", obs_status, 1);
      check_output("bad_tries", obs_tries, t);
    end
    apply_stimulus(100, 1111, 0, 0, 1);
    check_output("locked_status", obs_status, 3);
    check_output("locked_tries", obs_tries, 3);

    pulse_unlock(0);
    apply_stimulus(100, 1111, 0, 0, 1);
    check_output("unlock_ok_status", obs_status, 0);
    check_output("unlock_ok_tries", obs_tries, 0);

    // Unlock held through the compare of the same user wins over the increment.
    apply_stimulus(100, 5, 1, 0, 1);
    check_output("unlock_race_status", obs_status, 1);
    check_output("unlock_race_tries", obs_tries, 0);

    // Out-of-range unlock index leaves user 1's count alone.
    apply_stimulus(200, 7, 0, 0, 1);
    pulse_unlock(5);
    apply_stimulus(200, 9, 0, 0, 1);
    check_output("oob_unlock_tries", obs_tries, 2);
    apply_stimulus(200, 1222, 0, 0, 1);
    check_output("ok200_tries", obs_tries, 0);

    // Duplicate card: lowest index wins, index 3 never read.
    store_card[3] = 10'd200;
    apply_stimulus(200, 1222, 0, 0, 1);
    check_output("dup_idx", obs_idx, 1);
    check_output("dup_lat", obs_lat, 5);
    check_output("dup_addrs", addr_log.size(), 2);
    store_card[3] = 10'd400;

    // Reset in the middle of a card-500 scan: no response, counters cleared.
    apply_stimulus(200, 7, 0, 0, 1);
    check_output("pre_rst_tries", obs_tries, 1);
    apply_stimulus(500, 1555, 0, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b0;
    rst_n = 1'b0;
    txn_active = 1'b0;
    for (int i = 0; i <= N; i++) model_fail[i] = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_output("post_rst_ready", int'(req_ready), 1);
    check_output("post_rst_resp_valid", int'(resp_valid), 0);
    chk_en = 1'b1;
    repeat (15) @(negedge clk);
    check_output("abandoned_resp", int'(resp_seen), 0);
    apply_stimulus(200, 7, 0, 0, 1);
    check_output("post_rst_tries", obs_tries, 1);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
